// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU controller and decoder,
// the sequencer state encoding, and the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_ORI  = 4'd8;
    localparam logic [3:0] ALU_BEQ  = 4'd9;
    localparam logic [3:0] ALU_BNE  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_illegal(input logic [3:0] code);
        return code > ALU_MUL;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine for the multi-cycle ops: one-bit-per-step left shift and
// radix-2 shift-add multiply, with the shared step counter.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mul_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] res
);

    localparam logic [5:0] MUL_LAST = 6'(WIDTH - 1);

    logic             mul_q;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign last    = mul_q ? (cnt == MUL_LAST) : (cnt == 6'd1);
    // Value the register would hold after the current step; captured on the last one.
    assign res     = mul_q ? acc_nxt : (shreg << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_q <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            mul_q <= mul_mode;
            cnt   <= mul_mode ? 6'd0 : {1'b0, shamt};
        end else if (step) begin
            cnt   <= mul_q ? cnt + 6'd1 : cnt - 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            shreg  <= op_b;
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
        end else if (step) begin
            if (mul_q) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end else begin
                shreg  <= shreg << 1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/done handshake: single-cycle logic/add-class ops,
// iterative shift-left and shift-add multiply via alu_iter_core.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr,
                                     input logic is_sub);
        return ((sa ^ sb) == is_sub) && (sr != sa);
    endfunction

    state_t           state;
    logic             accept;
    logic             go_shift;
    logic             go_mul;
    logic             core_step;
    logic             core_last;
    logic [WIDTH-1:0] core_res;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_zero;
    logic             sc_ovf;
    logic             sc_ill;

    assign accept    = start_i && (state == ST_IDLE || state == ST_DONE);
    assign go_shift  = (ctrl_i == ALU_SLL) && (shamt_i != 5'd0);
    assign go_mul    = (ctrl_i == ALU_MUL);
    assign core_step = (state == ST_SHIFT) || (state == ST_MUL);

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (accept),
        .mul_mode (go_mul),
        .op_a     (src1_i),
        .op_b     (src2_i),
        .shamt    (shamt_i),
        .step     (core_step),
        .last     (core_last),
        .res      (core_res)
    );

    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_ill  = 1'b0;
        case (ctrl_i)
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = add_ovf(src1_i[WIDTH-1], src2_i[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = add_ovf(src1_i[WIDTH-1], src2_i[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            ALU_AND:  sc_res = src1_i & src2_i;
            ALU_OR:   sc_res = src1_i | src2_i;
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (src1_i < src2_i)};
            ALU_SLL:  sc_res = src2_i;
            ALU_LUI:  sc_res = {src2_i[15:0], {(WIDTH-16){1'b0}}};
            ALU_ORI:  sc_res = src1_i | {{(WIDTH-16){1'b0}}, src2_i[15:0]};
            ALU_BEQ,
            ALU_BNE:  sc_res = diff;
            default:  sc_ill = is_illegal(ctrl_i);
        endcase
        // Branch ops report "branch taken" on the zero flag.
        if (ctrl_i == ALU_BEQ)
            sc_zero = (diff == '0);
        else if (ctrl_i == ALU_BNE)
            sc_zero = (diff != '0);
        else
            sc_zero = (sc_res == '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
            illegal_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        overflow_o <= 1'b0;
                        illegal_o  <= 1'b0;
                        if (go_shift) begin
                            state  <= ST_SHIFT;
                            busy_o <= 1'b1;
                        end else if (go_mul) begin
                            state  <= ST_MUL;
                            busy_o <= 1'b1;
                        end else begin
                            state      <= ST_DONE;
                            done_o     <= 1'b1;
                            result_o   <= sc_res;
                            zero_o     <= sc_zero;
                            overflow_o <= sc_ovf;
                            illegal_o  <= sc_ill;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT, ST_MUL: begin
                    if (core_last) begin
                        state    <= ST_DONE;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                        result_o <= core_res;
                        zero_o   <= (core_res == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero, ovf, ill;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_i    (start),
        .ctrl_i     (ctrl),
        .src1_i     (src1),
        .src2_i     (src2),
        .shamt_i    (shamt),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .zero_o     (zero),
        .overflow_o (ovf),
        .illegal_o  (ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: what each op should produce and how many edges after acceptance done rises.
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic z,
                         output logic ov, output logic il, output int k);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0; ov = 1'b0; il = 1'b0; k = 0;
        case (c)
            4'd0:  begin r = a + b; s = sa + sb; ov = (s != longint'($signed(r))); end
            4'd1:  begin r = a - b; s = sa - sb; ov = (s != longint'($signed(r))); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  begin r = b << sh; k = int'(sh); end
            4'd7:  r = {b[15:0], 16'h0000};
            4'd8:  r = a | {16'h0000, b[15:0]};
            4'd9,
            4'd10: r = a - b;
            4'd11: begin r = a * b; k = 32; end
            default: il = 1'b1;
        endcase
        if (c == 4'd9)       z = (a == b);
        else if (c == 4'd10) z = (a != b);
        else                 z = (r == 32'd0);
    endtask

    // Issue one op, follow it to done, and check latency, busy window and flags.
    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input bit poke);
        logic [31:0] er;
        logic ez, eo, ei;
        int k, cyc, busy_n;
        model(c, a, b, sh, er, ez, eo, ei, k);
        ctrl = c; src1 = a; src2 = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom); shamt = 5'($urandom);
        cyc = 0; busy_n = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_n++;
            if (poke && cyc == 5) begin
                start = 1'b1; ctrl = 4'd0; src1 = 32'h1111_1111; src2 = 32'h2222_2222;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(k));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(k));
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
        chk({tag, ".overflow"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, ".illegal"}, {31'd0, ill}, {31'd0, ei});
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] er, a, b;
        logic ez, eo, ei;
        logic [3:0] c;
        int k;

        #2 rst_n = 1'b0;
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.flags", {29'd0, zero, ovf, ill}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
        do_op("sub_zero", 4'd1, 32'd5, 32'd5, 5'd0, 1'b0);
        do_op("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        do_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        do_op("beq", 4'd9, 32'd3, 32'd3, 5'd0, 1'b0);
        do_op("bne", 4'd10, 32'd3, 32'd3, 5'd0, 1'b0);
        do_op("lui", 4'd7, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
        do_op("ori", 4'd8, 32'hF000_0000, 32'hFFFF_00FF, 5'd0, 1'b0);
        do_op("sll31", 4'd6, 32'd0, 32'd1, 5'd31, 1'b0);
        do_op("sll0", 4'd6, 32'd0, 32'hA5A5_0001, 5'd0, 1'b0);
        do_op("sll1", 4'd6, 32'd0, 32'h8000_0001, 5'd1, 1'b0);
        do_op("mul7x6", 4'd11, 32'd7, 32'd6, 5'd0, 1'b0);
        do_op("mul_neg", 4'd11, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1);
        do_op("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0);

        // Back-to-back single-cycle adds with start held high.
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            ctrl = 4'd0; src1 = a; src2 = b;
            model(4'd0, a, b, 5'd0, er, ez, eo, ei, k);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d.done", i), {31'd0, done}, 32'd1);
            chk($sformatf("b2b%0d.result", i), result, er);
            chk($sformatf("b2b%0d.overflow", i), {31'd0, ovf}, {31'd0, eo});
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b.done_end", {31'd0, done}, 32'd0);

        // Abort a multiply partway through with an asynchronous reset.
        do_op("pre_abort", 4'd0, 32'h0000_0100, 32'h0000_0023, 5'd0, 1'b0);
        ctrl = 4'd11; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.result", result, 32'd0);
        chk("abort.flags", {29'd0, zero, ovf, ill}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("abort.no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            chk("abort.stays_idle", {30'd0, busy, done}, 32'd0);
        end
        do_op("post_abort_add", 4'd0, 32'd40, 32'd2, 5'd0, 1'b0);

        // Randomized ops across all codes.
        for (int i = 0; i < 30; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            do_op($sformatf("rand%0d", i), c, a, b, 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle ALU for the project CPU, directly downstream of the ALU controller. It consumes the 4-bit ALU control code and two 32-bit operands, and returns result, zero and overflow flags through a start/done handshake. Logic and add-class operations complete in one cycle. Shift-left is iterative at one bit per cycle, and the new multiply is a 32-step shift-add.

## Interface
- WIDTH, 32, operand/result width (only 32 is verified)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  request; accepted on an edge where busy_o=0
- ctrl_i  in  4  ALU control code: add 0, sub 1, and 2, or 3, slt 4, sltu 5, sll 6, lui 7, ori 8, beq 9, bne 10, mul 11
- src1_i  in  WIDTH  operand 1 (rs)
- src2_i  in  WIDTH  operand 2 (rt / immediate)
- shamt_i  in  5  shift amount for sll
- busy_o  out  1  high while iterating; start_i ignored
- done_o  out  1  one-cycle pulse, result valid
- result_o  out  WIDTH  result, held until next accepted start
- zero_o  out  1  branch/zero flag, held with result
- overflow_o  out  1  signed overflow (add/sub only), held
- illegal_o  out  1  ctrl code 12–15 seen, held

## Operation
- States: IDLE, SHIFT, MUL, DONE. Reset enters IDLE.
- IDLE or DONE with start_i=1: latch ctrl_i, src1_i, src2_i and shamt_i. Then go:
  - to SHIFT for sll with shamt≠0;
  - to MUL for mul;
  - to DONE for all other codes, with the result computed and registered at the same edge.
- SHIFT: shift the operand register left 1 per edge and decrement the counter. When the counter reaches 1, register the result and go to DONE.
- MUL: run radix-2 shift-add for 32 edges using a 6-bit counter. Keep the low 32 bits of the product. At the 32nd step, go to DONE.
- DONE: done_o=1 for exactly this cycle. Then go to IDLE, unless start_i=1, in which case accept back-to-back.
- Per-operation results:
  - add/sub: two's complement. overflow_o is set when both operand signs are equal (add) or differ (sub) and the result sign differs from src1.
  - and/or: bitwise.
  - slt: signed compare, result 1/0. sltu: unsigned compare, result 1/0.
  - sll: src2 << shamt.
  - lui: {src2[15:0], 16'h0}.
  - ori: src1 | {16'h0, src2[15:0]}.
  - beq/bne: result = src1−src2. zero_o = (result==0) for beq and (result≠0) for bne, so zero_o means "branch taken".
  - All other ops: zero_o = (result==0).
- Illegal code (12–15): result 0, zero_o 1, illegal_o 1, completes as a single-cycle op.
- overflow_o and illegal_o are cleared at every accepted start.
- start_i while busy_o=1 is dropped without effect. ctrl_i and operands need only be valid on the accepting edge.

## Timing
- Reset (asynchronous, rst_i=0) clears everything, including mid-operation: state=IDLE, and busy_o, done_o, result_o, zero_o, overflow_o and illegal_o all 0. Any in-flight operation is aborted with no done_o.
- Let E0 be the accepting edge. done_o rises at edge E0+k:
  - k=0 for single-cycle ops and for sll with shamt=0;
  - k=shamt for sll (so shamt=31 gives k=31);
  - k=32 for mul.
- busy_o is high from E0 to E0+k for k>0. It is never high for k=0.
- Throughput is one single-cycle op per cycle, because start is accepted in DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package alu_pkg holds the ctrl code localparams (0–11), the state encoding, and the WIDTH default. The ALU controller and the decoder import the same codes.
- Sub-module alu_iter_core holds the shift register, multiplicand/multiplier/accumulator, and step counter. It exposes load/step/last. The top level holds the FSM, the single-cycle datapath and the flag logic.

## Test plan
- Reset, then single-cycle ops:
  - add 0x7FFFFFFF+1 → done at E0, result 0x80000000, overflow_o 1.
  - sub 5−5 → zero_o 1.
  - slt −1 vs 1 → result 1; sltu −1 vs 1 → result 0.
- Branches:
  - beq 3,3 → zero_o 1; bne 3,3 → zero_o 0.
  - lui src2=0x1234 → result 0x12340000.
  - ori src1=0xF0000000, src2=0xFFFF00FF → result 0xF00000FF.
- sll:
  - src2=1, shamt=31 → busy_o high for 31 cycles, done at E0+31, result 0x80000000.
  - shamt=0 → done at E0.
- mul:
  - 7×6 → done at E0+32, result 42.
  - 0xFFFFFFFF×2 → result 0xFFFFFFFE.
  - A start_i pulse during busy is ignored, and the result is unchanged.
- Back-to-back: start held high across three adds → done_o high three consecutive cycles with the correct results. A ctrl=13 request yields illegal_o 1 and result 0.
- Reset mid-mul at cycle 10 → all outputs 0 immediately, no done_o. The next add completes normally.
